modexpt_arb: RTL and testbench

MODEXPT_ARB -- requirements
Module: modexpt_arb

---
 rtl/modexpt_arb.sv | 190 +++++++++++++++++++
 tb/tb_modexpt_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexpt_arb.sv
// Two-port round-robin front end for a modular-exponentiation engine.
// Toggle handshakes on both sides; trivial modulus/exponent jobs bypass the engine.
module modexpt_arb #(
  parameter int I_MSB = 3,
  parameter int J_MSB = 3,
  parameter int TMO   = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       req0,
  input  logic                       req1,
  output logic                       ack0,
  output logic                       ack1,
  input  logic [(2**(I_MSB+1))-1:0]  base0,
  input  logic [(2**(I_MSB+1))-1:0]  base1,
  input  logic [(2**(J_MSB+1))-1:0]  exp0,
  input  logic [(2**(J_MSB+1))-1:0]  exp1,
  input  logic [(2**(I_MSB+1))-1:0]  mod0,
  input  logic [(2**(I_MSB+1))-1:0]  mod1,
  output logic [(2**(I_MSB+1))-1:0]  res0,
  output logic [(2**(I_MSB+1))-1:0]  res1,
  output logic                       err0,
  output logic                       err1,
  output logic                       eng_req,
  input  logic                       eng_ack,
  output logic [(2**(I_MSB+1))-1:0]  eng_rx_data_1,
  output logic [(2**(J_MSB+1))-1:0]  eng_rx_data_2,
  output logic [J_MSB+1:0]           eng_rx_data_2_msb,
  output logic [(2**(I_MSB+1))-1:0]  eng_rx_data_3,
  input  logic [(2**(I_MSB+1))-1:0]  eng_tx_data,
  output logic                       eng_enable
);

  localparam int DW = 2**(I_MSB+1);
  localparam int EW = 2**(J_MSB+1);
  localparam int MW = J_MSB+2;
  localparam logic [15:0] TMO_C = 16'(TMO);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d, last_q, last_d;
  logic [1:0]    seen_q, seen_d, ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] res0_q, res0_d, res1_q, res1_d;
  logic          eng_req_q, eng_req_d, eng_en_q, eng_ack_q;
  logic [DW-1:0] rx1_q, rx1_d, rx3_q, rx3_d;
  logic [EW-1:0] rx2_q, rx2_d;
  logic [MW-1:0] msb_q, msb_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [1:0]    req, pend;
  logic          gnt_pick, res_wr;
  logic [DW-1:0] op_base, op_mod, res_new;
  logic [EW-1:0] op_exp;

  function automatic logic [MW-1:0] msb_idx(input logic [EW-1:0] e);
    msb_idx = '0;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) msb_idx = MW'(i);
    end
  endfunction

  assign req      = {req1, req0};
  assign pend     = req ^ seen_q;
  assign gnt_pick = (pend == 2'b11) ? ~last_q : pend[1];
  assign op_base  = gnt_q ? base1 : base0;
  assign op_exp   = gnt_q ? exp1  : exp0;
  assign op_mod   = gnt_q ? mod1  : mod0;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    seen_d    = seen_q;
    ack_d     = ack_q;
    err_d     = err_q;
    eng_req_d = eng_req_q;
    rx1_d     = rx1_q;
    rx2_d     = rx2_q;
    rx3_d     = rx3_q;
    msb_d     = msb_q;
    cnt_d     = cnt_q;
    res_wr    = 1'b0;
    res_new   = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && (pend != 2'b00)) begin
          gnt_d            = gnt_pick;
          last_d           = gnt_pick;
          seen_d[gnt_pick] = req[gnt_pick];
          state_d          = LOAD;
        end
      end
      LOAD: begin
        rx1_d = op_base;
        rx2_d = op_exp;
        rx3_d = op_mod;
        msb_d = msb_idx(op_exp);
        if (op_mod == '0) begin
          res_wr       = 1'b1;
          err_d[gnt_q] = 1'b1;
          state_d      = DONE;
        end else if (op_exp == '0) begin
          // x^0 = 1, except everything is 0 modulo 1
          res_wr       = 1'b1;
          res_new      = (op_mod == DW'(1)) ? '0 : DW'(1);
          err_d[gnt_q] = 1'b0;
          state_d      = DONE;
        end else begin
          eng_req_d = ~eng_req_q;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (eng_ack && !eng_ack_q) begin
          res_wr       = 1'b1;
          res_new      = eng_tx_data;
          err_d[gnt_q] = 1'b0;
          state_d      = DONE;
        end else if (cnt_q == TMO_C) begin
          err_d[gnt_q] = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        ack_d[gnt_q] = ~ack_q[gnt_q];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    res0_d = (res_wr && !gnt_q) ? res_new : res0_q;
    res1_d = (res_wr &&  gnt_q) ? res_new : res1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      seen_q    <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      eng_req_q <= 1'b0;
      eng_en_q  <= 1'b0;
      eng_ack_q <= 1'b0;
      rx1_q     <= '0;
      rx2_q     <= '0;
      rx3_q     <= '0;
      msb_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      eng_req_q <= eng_req_d;
      eng_en_q  <= enable;
      eng_ack_q <= eng_ack;
      rx1_q     <= rx1_d;
      rx2_q     <= rx2_d;
      rx3_q     <= rx3_d;
      msb_q     <= msb_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ack0              = ack_q[0];
  assign ack1              = ack_q[1];
  assign err0              = err_q[0];
  assign err1              = err_q[1];
  assign res0              = res0_q;
  assign res1              = res1_q;
  assign eng_req           = eng_req_q;
  assign eng_enable        = eng_en_q;
  assign eng_rx_data_1     = rx1_q;
  assign eng_rx_data_2     = rx2_q;
  assign eng_rx_data_2_msb = msb_q;
  assign eng_rx_data_3     = rx3_q;

endmodule

// File: tb/tb_modexpt_arb.sv
// Bench for modexpt_arb: directed scenarios plus random jobs against a job-level
// reference model and a behavioural modexp engine.
module tb_modexpt_arb;
  localparam int TMO = 20;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, ack0, ack1, err0, err1;
  logic [15:0] base0 = '0, base1 = '0, exp0 = '0, exp1 = '0, mod0 = '0, mod1 = '0;
  logic [15:0] res0, res1;
  logic        eng_req, eng_enable, eng_ack = 1'b0;
  logic [15:0] eng_rx_data_1, eng_rx_data_2, eng_rx_data_3, eng_tx_data = '0;
  logic [4:0]  eng_rx_data_2_msb;

  int n_checks = 0;
  int n_errors = 0;

  int   eng_lat = 2;
  bit   eng_dead = 1'b0, eng_spurious = 1'b0, eng_busy = 1'b0;
  int   eng_cnt = 0, eng_toggles = 0;
  logic eng_req_prev = 1'b0;

  logic [15:0] model_res [2];
  logic        model_err [2];
  int          model_last;

  modexpt_arb #(.I_MSB(3), .J_MSB(3), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
    .base0(base0), .base1(base1), .exp0(exp0), .exp1(exp1), .mod0(mod0), .mod1(mod1),
    .res0(res0), .res1(res1), .err0(err0), .err1(err1),
    .eng_req(eng_req), .eng_ack(eng_ack),
    .eng_rx_data_1(eng_rx_data_1), .eng_rx_data_2(eng_rx_data_2),
    .eng_rx_data_2_msb(eng_rx_data_2_msb), .eng_rx_data_3(eng_rx_data_3),
    .eng_tx_data(eng_tx_data), .eng_enable(eng_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    longint unsigned r, x;
    if (m == 0) return 16'd0;
    r = 1 % m;
    x = b % m;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return 16'(r);
  endfunction

  function automatic int msb_ref(input logic [15:0] e);
    int k = 0;
    int v = int'(e);
    while (v > 1) begin
      v = v / 2;
      k++;
    end
    return k;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Behavioural engine: answers each eng_req toggle after eng_lat cycles with a one-cycle eng_ack pulse.
  always @(negedge clk) begin
    if (eng_ack) eng_ack = 1'b0;
    if (rst) begin
      eng_busy     = 1'b0;
      eng_req_prev = eng_req;
    end else if (eng_req !== eng_req_prev) begin
      eng_req_prev = eng_req;
      eng_toggles++;
      eng_busy = !eng_dead;
      eng_cnt  = eng_lat;
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt <= 0) begin
        eng_tx_data = modexp(eng_rx_data_1, eng_rx_data_2, eng_rx_data_3);
        eng_ack     = 1'b1;
        eng_busy    = 1'b0;
      end
    end else if (eng_spurious) begin
      eng_ack      = 1'b1;
      eng_spurious = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"}, {ack1, ack0}, 0);
    check_val({tag, "_eng"}, {eng_req, eng_enable}, 0);
    check_val({tag, "_res"}, {res1, res0}, 0);
    check_val({tag, "_err"}, {err1, err0}, 0);
    check_val({tag, "_rx"}, {eng_rx_data_1, eng_rx_data_2, eng_rx_data_3, eng_rx_data_2_msb}, 0);
  endtask

  task automatic run_job(input string tag, input int p, input logic [15:0] b, input logic [15:0] e,
                         input logic [15:0] m, input int lat, input bit dead, input bit hold_en);
    logic [15:0] x_res;
    logic        x_err, a_start, a_now;
    int          x_lat, x_tog, cyc, tog0;
    if (m == 0) begin
      x_res = 0; x_err = 1; x_lat = 3; x_tog = 0;
    end else if (e == 0) begin
      x_res = (m == 1) ? 16'd0 : 16'd1; x_err = 0; x_lat = 3; x_tog = 0;
    end else if (dead) begin
      x_res = model_res[p]; x_err = 1; x_lat = TMO + 4; x_tog = 1;
    end else begin
      x_res = modexp(b, e, m); x_err = 0; x_lat = lat + 4; x_tog = 1;
    end
    eng_lat  = lat;
    eng_dead = dead;
    if (p == 0) begin base0 = b; exp0 = e; mod0 = m; end
    else        begin base1 = b; exp1 = e; mod1 = m; end
    if (hold_en) enable = 1'b0;
    a_start = (p == 0) ? ack0 : ack1;
    tog0    = eng_toggles;
    if (p == 0) req0 = ~req0; else req1 = ~req1;
    if (hold_en) begin
      repeat (6) @(negedge clk);
      check_val({tag, "_held_ack"}, (p == 0) ? ack0 : ack1, a_start);
      check_val({tag, "_held_eng"}, eng_toggles - tog0, 0);
      enable = 1'b1;
      #1 check_val({tag, "_en_reg"}, eng_enable, 0);
    end
    cyc   = 0;
    a_now = a_start;
    while (a_now == a_start && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (hold_en && cyc == 1) check_val({tag, "_en_on"}, eng_enable, 1);
      a_now = (p == 0) ? ack0 : ack1;
    end
    check_val({tag, "_lat"}, cyc, x_lat);
    check_val({tag, "_res"}, (p == 0) ? res0 : res1, x_res);
    check_val({tag, "_err"}, (p == 0) ? err0 : err1, x_err);
    check_val({tag, "_engtog"}, eng_toggles - tog0, x_tog);
    if (x_tog == 1) begin
      check_val({tag, "_rx"}, {eng_rx_data_1, eng_rx_data_2, eng_rx_data_3}, {b, e, m});
      check_val({tag, "_msb"}, eng_rx_data_2_msb, msb_ref(e));
    end
    model_res[p] = x_res;
    model_err[p] = x_err;
    model_last   = p;
  endtask

  task automatic run_tie(input string tag, input logic [15:0] b0, input logic [15:0] e0, input logic [15:0] m0,
                         input logic [15:0] b1, input logic [15:0] e1, input logic [15:0] m1, input int lat);
    int   t0 = -1, t1 = -1, cyc = 0, first_x;
    logic a0s, a1s;
    first_x  = (model_last == 1) ? 0 : 1;
    base0 = b0; exp0 = e0; mod0 = m0;
    base1 = b1; exp1 = e1; mod1 = m1;
    eng_lat  = lat;
    eng_dead = 1'b0;
    a0s = ack0;
    a1s = ack1;
    req0 = ~req0;
    req1 = ~req1;
    while ((t0 < 0 || t1 < 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (t0 < 0 && ack0 != a0s) t0 = cyc;
      if (t1 < 0 && ack1 != a1s) t1 = cyc;
    end
    check_val({tag, "_both_done"}, (t0 > 0 && t1 > 0), 1);
    check_val({tag, "_first"}, (t0 < t1) ? 0 : 1, first_x);
    check_val({tag, "_t_first"}, (first_x == 0) ? t0 : t1, lat + 4);
    check_val({tag, "_t_second"}, (first_x == 0) ? t1 : t0, 2 * lat + 8);
    check_val({tag, "_res0"}, res0, modexp(b0, e0, m0));
    check_val({tag, "_res1"}, res1, modexp(b1, e1, m1));
    check_val({tag, "_err"}, {err1, err0}, 0);
    model_res[0] = modexp(b0, e0, m0);
    model_res[1] = modexp(b1, e1, m1);
    model_err[0] = 0;
    model_err[1] = 0;
    model_last   = 1 - first_x;
  endtask

  initial begin
    int          p, lat, cyc;
    bit          dead;
    logic [15:0] b, e, m;
    logic [1:0]  acks;

    model_res[0] = 0; model_res[1] = 0;
    model_err[0] = 0; model_err[1] = 0;
    model_last   = 1;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_tie("tieA", 16'd3, 16'd5, 16'd7, 16'd2, 16'd10, 16'd1000, 2);
    run_job("basic", 0, 16'd4, 16'd13, 16'd497, 3, 1'b0, 1'b1);
    check_val("basic_res445", res0, 16'd445);
    run_tie("tieB", 16'd9, 16'd7, 16'd31, 16'd11, 16'd3, 16'd17, 1);

    run_job("mod0", 1, 16'd5, 16'd6, 16'd0, 2, 1'b0, 1'b0);
    run_job("exp0_mod1", 1, 16'd5, 16'd0, 16'd1, 2, 1'b0, 1'b0);
    run_job("exp0_mod9", 1, 16'd5, 16'd0, 16'd9, 2, 1'b0, 1'b0);

    acks = {ack1, ack0};
    eng_spurious = 1'b1;
    repeat (5) @(negedge clk);
    check_val("spurious_ack", {ack1, ack0}, acks);
    run_job("after_spur", 0, 16'd12, 16'd1, 16'd100, 1, 1'b0, 1'b0);

    run_job("tmo", 0, 16'd7, 16'd3, 16'd11, 2, 1'b1, 1'b0);

    if (req0) run_job("pre0", 0, 16'd1, 16'd1, 16'd0, 1, 1'b0, 1'b0);
    if (req1) run_job("pre1", 1, 16'd1, 16'd1, 16'd0, 1, 1'b0, 1'b0);
    base0 = 16'd5; exp0 = 16'd3; mod0 = 16'd13;
    eng_dead = 1'b1;
    acks = {ack1, ack0};
    req0 = 1'b1;
    repeat (6) @(negedge clk);
    check_val("rstw_noack", {ack1, ack0}, acks);
    rst = 1'b1;
    eng_dead = 1'b0;
    eng_lat  = 2;
    repeat (2) @(negedge clk);
    check_all_zero("rstw");
    rst = 1'b0;
    model_res[0] = 0; model_res[1] = 0;
    model_err[0] = 0; model_err[1] = 0;
    model_last   = 1;
    cyc = 0;
    while (ack0 == 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rstw_repend_lat", cyc, 6);
    check_val("rstw_repend_res", res0, modexp(16'd5, 16'd3, 16'd13));
    check_val("rstw_repend_err", err0, 0);
    check_val("rstw_ack1", ack1, 0);
    model_res[0] = modexp(16'd5, 16'd3, 16'd13);
    model_last   = 0;
    run_job("post_rst", 1, 16'd6, 16'd9, 16'd23, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      p    = int'($urandom_range(0, 1));
      b    = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 9))
        0:       m = 16'd0;
        1:       m = 16'd1;
        default: m = 16'($urandom_range(2, 65535));
      endcase
      e    = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      lat  = int'($urandom_range(1, 6));
      dead = ($urandom_range(0, 9) == 0);
      run_job("rand", p, b, e, m, lat, dead, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
